alu_control_pipe: RTL
=====================

Name: alu_control_pipe

Overview:
- Registered, handshaked successor of the ALU control decoder.
- Accepts {alu_op, func_op} from the main control / decode stage through a valid/ready interface and decodes it to a CTRL_W-bit ALU control word.
- Adds R-type nor/mult/div, illegal-op flagging and a multi-cycle hold for mult/div, so the ALU/execute stage can be back-pressured.
- Sits between decode and execute.

Parameters:
- FUNC_W, 6: funct field width; codes below are 6-bit, zero-extended/truncated to FUNC_W.
- CTRL_W, 4: control word width (>=4); encodings below are zero-extended.
- MD_CYCLES, 8: cycles a mult/div occupies before its output is valid (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- alu_op  in  2  main-control ALU op class
- func_op  in  FUNC_W  R-type funct field
- out_valid  out  1  alu_control_sig/illegal valid
- out_ready  in  1  execute stage accepts output
- alu_control_sig  out  CTRL_W  decoded ALU control word
- illegal  out  1  request had no legal decode
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, alu_control_sig=0, illegal=0, busy=0, counter=0. Asserting reset mid-operation (any state) aborts: the in-flight op is discarded and no out_valid follows.
- Decode:
  - alu_op 00 -> 0010 (add)
  - alu_op 01 -> 0110 (sub)
  - alu_op 11 -> 0001 (or-immediate)
  - alu_op 10, func_op:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100111 -> 1100 (nor)
    - 011000 -> 1000 (mult, multi-cycle)
    - 011010 -> 1001 (div, multi-cycle)
    - any other -> all-ones with illegal=1
  - Full funct compare; no partial-bit matching.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). Combinational from state and out_ready only; never depends on in_valid.
- States:
  - IDLE: out_valid=0. On input transfer of a single-cycle op (including illegal) -> HOLD, output registered at that edge. On mult/div -> MULTI, counter=MD_CYCLES-1, busy=1. If MD_CYCLES==1, mult/div behaves as single-cycle.
  - HOLD: out_valid=1; output stable while out_ready=0. On output transfer: with a simultaneous input transfer, load the new op (HOLD or MULTI as above; back-to-back single-cycle ops give one result per cycle); otherwise -> IDLE.
  - MULTI: out_valid=0, in_ready=0, busy=1, counter decrements each cycle. At counter==1 the next edge goes to HOLD with busy=0.
- Latency:
  - Single-cycle: accepted at edge N -> out_valid high from edge N.
  - Mult/div: out_valid after MD_CYCLES edges from acceptance.
- alu_control_sig/illegal hold their last value when out_valid=0.
- in_valid while in_ready=0 is ignored; the upstream stage holds it.

Optional Feature:
- Macro ALU_CTRL_STATS_EN.
- Defined: adds output illegal_count [7:0], reset to 0, incremented on each input transfer that decodes illegal, saturating at 255.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then alu_op=10, func=100000, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, sig=0010, illegal=0; following cycle out_valid=0.
- Stream alu_op=10 with funcs 100010, 100100, 101010 on consecutive cycles, out_ready=1 -> in_ready stays 1; outputs 0110, 0000, 0111 on consecutive cycles.
- alu_op=10, func=011000, MD_CYCLES=8 -> busy=1 and in_ready=0 for 7 cycles; out_valid=1 with sig=1000 on the 8th edge after acceptance; busy=0.
- Hold out_ready=0 after an alu_op=01 result -> sig=0110 stable, in_ready=0 until out_ready=1; a new request accepted in that same cycle appears next cycle.
- alu_op=10, func=111111 -> illegal=1, sig=1111; with ALU_CTRL_STATS_EN, illegal_count=1, and after 300 illegal ops it reads 255.
- Assert rst_n=0 three cycles into a div -> all outputs 0 immediately; after release no out_valid appears and in_ready=1.

Source files
------------

// File: rtl/alu_control_pipe_if.sv
// Request/response bundle between decode and the ALU control pipe.
// Upstream drives the request side and the response ready.
// The pipe drives request ready and the decoded response.
interface alu_control_pipe_if #(
   parameter int FUNC_W = 6,
   parameter int CTRL_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        alu_op;
   logic [FUNC_W-1:0] func_op;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] alu_control_sig;
   logic              illegal;
   logic              busy;

   // Decode stage / execute stage side
   modport master (
      output in_valid, alu_op, func_op, out_ready,
      input  in_ready, out_valid, alu_control_sig, illegal, busy
   );

   // ALU control pipe side
   modport slave (
      input  in_valid, alu_op, func_op, out_ready,
      output in_ready, out_valid, alu_control_sig, illegal, busy
   );
endinterface

// File: rtl/alu_control_pipe.sv
// Purpose: decode {alu_op, func_op} into a registered ALU control word, flag illegal funct codes.
// Latency: single-cycle ops valid from the accepting edge; mult/div valid MD_CYCLES-1 edges later.
// Backpressure: result held while out_ready=0; in_ready only in IDLE or HOLD with out_ready.
// Optional: define ALU_CTRL_STATS_EN to add the saturating illegal_count output.
module alu_control_pipe #(
   parameter int FUNC_W    = 6,
   parameter int CTRL_W    = 4,
   parameter int MD_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_control_pipe_if.slave    bus
`ifdef ALU_CTRL_STATS_EN
   ,
   output logic [7:0]           illegal_count
`endif
);

   localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(6'b100000);
   localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(6'b100010);
   localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(6'b100100);
   localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(6'b100101);
   localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(6'b101010);
   localparam logic [FUNC_W-1:0] F_NOR  = FUNC_W'(6'b100111);
   localparam logic [FUNC_W-1:0] F_MULT = FUNC_W'(6'b011000);
   localparam logic [FUNC_W-1:0] F_DIV  = FUNC_W'(6'b011010);

   localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0111);
   localparam logic [CTRL_W-1:0] C_NOR  = CTRL_W'(4'b1100);
   localparam logic [CTRL_W-1:0] C_MULT = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] C_DIV  = CTRL_W'(4'b1001);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      MULTI = 2'd2
   } state_t;

   typedef struct packed {
      logic              ill;
      logic              md;
      logic [CTRL_W-1:0] ctrl;
   } dec_t;

   // Full-width funct compare; anything unlisted under alu_op 10 is illegal.
   function automatic dec_t decode(input logic [1:0] op, input logic [FUNC_W-1:0] fn);
      dec_t d;
      d.ill  = 1'b0;
      d.md   = 1'b0;
      d.ctrl = C_AND;
      case (op)
         2'b00: d.ctrl = C_ADD;
         2'b01: d.ctrl = C_SUB;
         2'b11: d.ctrl = C_OR;
         default: begin
            if (fn == F_ADD)       d.ctrl = C_ADD;
            else if (fn == F_SUB)  d.ctrl = C_SUB;
            else if (fn == F_AND)  d.ctrl = C_AND;
            else if (fn == F_OR)   d.ctrl = C_OR;
            else if (fn == F_SLT)  d.ctrl = C_SLT;
            else if (fn == F_NOR)  d.ctrl = C_NOR;
            else if (fn == F_MULT) begin d.ctrl = C_MULT; d.md = 1'b1; end
            else if (fn == F_DIV)  begin d.ctrl = C_DIV;  d.md = 1'b1; end
            else begin
               d.ctrl = '1;
               d.ill  = 1'b1;
            end
         end
      endcase
      return d;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              md_div_q, md_div_d;
   logic [CTRL_W-1:0] sig_q, sig_d;
   logic              illegal_q, illegal_d;

   logic              in_ready;
   logic              accept;
   logic              load_new;
   dec_t              dec;

   // Next-state: accept into HOLD/MULTI, drain HOLD, count down MULTI.
   always_comb begin
      in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
      accept    = bus.in_valid && in_ready;
      dec       = decode(bus.alu_op, bus.func_op);
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_div_d  = md_div_q;
      sig_d     = sig_q;
      illegal_d = illegal_q;
      load_new  = 1'b0;

      case (state_q)
         IDLE: load_new = accept;
         HOLD: begin
            if (bus.out_ready) begin
               state_d  = IDLE;
               load_new = accept;
            end
         end
         MULTI: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d   = HOLD;
               sig_d     = md_div_q ? C_DIV : C_MULT;
               illegal_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Output regs stay untouched on entry to MULTI so the last result holds.
      if (load_new) begin
         if (dec.md && (MD_CYCLES > 1)) begin
            state_d  = MULTI;
            cnt_d    = CNT_INIT;
            md_div_d = (dec.ctrl == C_DIV);
         end else begin
            state_d   = HOLD;
            sig_d     = dec.ctrl;
            illegal_d = dec.ill;
         end
      end
   end

   // State and output registers; reset aborts any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         md_div_q  <= 1'b0;
         sig_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         md_div_q  <= md_div_d;
         sig_q     <= sig_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.out_valid       = (state_q == HOLD);
   assign bus.busy            = (state_q == MULTI);
   assign bus.alu_control_sig = sig_q;
   assign bus.illegal         = illegal_q;

`ifdef ALU_CTRL_STATS_EN
   logic [7:0] ill_cnt_q, ill_cnt_d;

   // Count accepted illegal requests, saturating at 255.
   always_comb begin
      ill_cnt_d = ill_cnt_q;
      if (accept && dec.ill && (ill_cnt_q != 8'hFF)) ill_cnt_d = ill_cnt_q + 8'd1;
   end

   // Illegal counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ill_cnt_q <= 8'd0;
      else        ill_cnt_q <= ill_cnt_d;
   end

   assign illegal_count = ill_cnt_q;
`endif

endmodule
